spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all internal state is in this domain.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port SPI_SCK, input, 1 bit: SPI serial clock from the master, asynchronous to clk.
REQ-004 SHALL have port SPI_SS, input, 1 bit: active-low slave select from the master.
REQ-005 SHALL have port SPI_MOSI, input, 1 bit: master-to-slave serial data.
REQ-006 SHALL have port SPI_MISO, output, 1 bit: slave-to-master serial data.
REQ-007 SHALL have port wr_buffer_free, output, 1 bit: high when the transmit buffer can accept a word.
REQ-008 SHALL have port wr_en, input, 1 bit: one-cycle write strobe for the transmit buffer.
REQ-009 SHALL have port wr_data, input, 24 bits: transmit payload.
REQ-010 SHALL have port rd_data_available, output, 1 bit: high while an unacknowledged received frame is held.
REQ-011 SHALL have port rd_ack, input, 1 bit: one-cycle acknowledge that releases the received frame.
REQ-012 SHALL have port rd_data, output, 32 bits: last accepted received frame.

Function
REQ-013 SHALL pass SPI_SCK, SPI_SS and SPI_MOSI through 2-flop synchronizers into clk and detect SCK edges there; clk SHALL be at least 4x SCK frequency.
REQ-014 SHALL implement SPI mode 0: MOSI sampled on SCK rising edge, MISO updated on SCK falling edge, bytes MSB-first.
REQ-015 SHALL treat a frame as 32 SCK rising edges while SS is low; SS falling resets the bit counter.
REQ-016 SHALL assemble received bytes little-endian: byte 0 -> rd_data[7:0] (opcode), byte 1 -> [15:8], byte 2 -> [23:16], byte 3 -> [31:24].
REQ-017 SHALL, at most 4 clk cycles after the 32nd SCK rising edge at the pin, load rd_data and set rd_data_available.
REQ-018 SHALL clear rd_data_available in the cycle after rd_ack is sampled high; rd_data keeps its value.
REQ-019 SHALL ignore rd_ack while rd_data_available is low.
REQ-020 SHALL, when a frame completes in the same cycle as rd_ack, load the new frame and keep rd_data_available high.
REQ-021 SHALL discard a frame that completes while rd_data_available is high and not being acked, leaving rd_data unchanged.
REQ-022 SHALL discard a partial frame (fewer than 32 bits) when SS rises; no rd_data_available pulse.
REQ-023 SHALL, on wr_en high with wr_buffer_free high, store wr_data and drive wr_buffer_free low on the next cycle.
REQ-024 SHALL ignore wr_en while wr_buffer_free is low.
REQ-025 SHALL, on synchronized SS falling, move a full buffer into the 32-bit transmit shift register as {wr_data[23:16], wr_data[15:8], wr_data[7:0], 8'h01}, sent low byte first; wr_buffer_free SHALL rise the following cycle.
REQ-026 SHALL, when the buffer is empty at SS falling, load 32'h0 (status byte 8'h00 marks no data).
REQ-027 SHALL present the first MISO bit (bit 7 of the status byte) within 3 clk cycles of SS falling and shift on each SCK falling edge.
REQ-028 SHALL drive SPI_MISO low while SS is high.
REQ-029 SHALL, when a frame ends early, drop its unsent transmit bits; the word is not resent.

Reset
REQ-030 SHALL, while reset is high, force rd_data=0, rd_data_available=0, wr_buffer_free=1, SPI_MISO=0, empty the transmit buffer and clear bit counters and synchronizers.
REQ-031 SHALL, when reset is asserted mid-frame, abandon the frame; after release, the next SS falling starts a fresh frame.

Verification
REQ-032 SHALL pass: reset, then master sends bytes 01,AA,BB,CC -> rd_data=32'hCCBBAA01, rd_data_available=1 until one cycle after rd_ack.
REQ-033 SHALL pass: wr_en with wr_data=24'h123456 -> wr_buffer_free=0; next frame MISO bytes 01,56,34,12; wr_buffer_free=1 after SS falling.
REQ-034 SHALL pass: frame with empty buffer -> MISO returns 00,00,00,00.
REQ-035 SHALL pass: two frames sent without rd_ack -> rd_data holds the first frame; the second is dropped.
REQ-036 SHALL pass: SS raised after 12 bits -> no rd_data_available; the following full frame is received correctly.
REQ-037 SHALL pass: wr_en pulsed twice while not free -> only the first word is transmitted.

Source files
------------

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// Oversampled SPI mode-0 slave. The SPI pins are brought into the clk domain
// through 2-flop synchronizers, and all serial activity is derived from edges
// detected there. clk must run at least 4x the SCK frequency.
//
// Each frame is 32 bits (4 bytes, MSB-first per byte):
//   - The received frame is reassembled little-endian (byte 0 -> rd_data[7:0])
//     and handed over through a one-deep rd_data / rd_data_available holding
//     register, which is released by rd_ack.
//   - The transmit side returns a status byte followed by a 24-bit payload
//     that the host pre-loads through a one-deep wr_data buffer.
//
// Ports
//   clk               system clock
//   reset             asynchronous active-high reset
//   SPI_SCK           SPI clock from master (asynchronous)
//   SPI_SS            active-low slave select (asynchronous)
//   SPI_MOSI          master-to-slave data (asynchronous)
//   SPI_MISO          slave-to-master data, low while deselected
//   wr_buffer_free    transmit buffer can accept a word
//   wr_en             write strobe for the transmit buffer
//   wr_data           24-bit transmit payload
//   rd_data_available an unacknowledged received frame is held
//   rd_ack            releases the held received frame
//   rd_data           last accepted received frame
// ---------------------------------------------------------------------------
module spi_slave (
    input  logic        clk,
    input  logic        reset,
    input  logic        SPI_SCK,
    input  logic        SPI_SS,
    input  logic        SPI_MOSI,
    output logic        SPI_MISO,
    output logic        wr_buffer_free,
    input  logic        wr_en,
    input  logic [23:0] wr_data,
    output logic        rd_data_available,
    input  logic        rd_ack,
    output logic [31:0] rd_data
);

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned PAY_W      = 24;

    localparam logic [7:0] STATUS_DATA  = 8'h01;
    localparam logic [7:0] STATUS_EMPTY = 8'h00;

    // Synchronizer stages, plus one extra stage on SCK and SS for edge detection.
    logic sck_meta;
    logic sck_sync;
    logic sck_prev;
    logic ss_meta;
    logic ss_sync;
    logic ss_prev;
    logic mosi_meta;
    logic mosi_sync;

    // Frame tracking and data path state.
    logic              frame_active;
    logic [CNT_W-1:0]  bit_cnt;
    logic [31:0]       rx_shift;
    logic [31:0]       tx_shift;
    logic [PAY_W-1:0]  tx_buf;

    // Combinational helpers.
    logic        sck_rise_c;
    logic        sck_fall_c;
    logic        ss_fall_c;
    logic        ss_rise_c;
    logic        rx_bit_c;
    logic        frame_done_c;
    logic [31:0] rx_word_c;
    logic [31:0] rx_frame_c;
    logic [31:0] tx_load_c;
    logic        ack_c;

    // ------------------------------------------------------------------
    // Pin synchronizers and edge history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            ss_meta   <= 1'b0;
            ss_sync   <= 1'b0;
            ss_prev   <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sck_meta  <= SPI_SCK;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            ss_meta   <= SPI_SS;
            ss_sync   <= ss_meta;
            ss_prev   <= ss_sync;
            mosi_meta <= SPI_MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    assign sck_rise_c = sck_sync & ~sck_prev;
    assign sck_fall_c = ~sck_sync & sck_prev;
    assign ss_fall_c  = ~ss_sync & ss_prev;
    assign ss_rise_c  = ss_sync & ~ss_prev;

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    // A bit is only taken inside a frame opened by an observed SS falling
    // edge, so a frame interrupted by reset is never resumed.
    assign rx_bit_c     = frame_active & sck_rise_c & (bit_cnt != CNT_W'(FRAME_BITS));
    assign frame_done_c = rx_bit_c & (bit_cnt == CNT_W'(FRAME_BITS - 1));
    assign rx_word_c    = {rx_shift[30:0], mosi_sync};

    // Shift register holds the first byte in its top byte; swap to little-endian.
    assign rx_frame_c = {rx_word_c[7:0], rx_word_c[15:8], rx_word_c[23:16], rx_word_c[31:24]};

    // Acks are meaningful only while a frame is held.
    assign ack_c = rd_ack & rd_data_available;

    // Frame window and bit counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_active <= 1'b0;
            bit_cnt      <= '0;
            rx_shift     <= '0;
        end else begin
            if (ss_fall_c) begin
                frame_active <= 1'b1;
                bit_cnt      <= '0;
                rx_shift     <= '0;
            end else if (ss_rise_c) begin
                // Partial frames are simply dropped here.
                frame_active <= 1'b0;
                bit_cnt      <= '0;
            end else if (rx_bit_c) begin
                bit_cnt  <= bit_cnt + CNT_W'(1);
                rx_shift <= rx_word_c;
            end
        end
    end

    // Received-frame holding register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data           <= '0;
            rd_data_available <= 1'b0;
        end else begin
            if (frame_done_c && (!rd_data_available || rd_ack)) begin
                // Free slot, or the old frame is being acked this cycle.
                rd_data           <= rx_frame_c;
                rd_data_available <= 1'b1;
            end else if (ack_c) begin
                rd_data_available <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    // Bytes go out status-first; the shift register is pre-ordered so the
    // whole word can be shifted out MSB-first.
    assign tx_load_c = wr_buffer_free
                     ? {STATUS_EMPTY, 24'h0}
                     : {STATUS_DATA, tx_buf[7:0], tx_buf[15:8], tx_buf[23:16]};

    // One-deep transmit buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_buf         <= '0;
            wr_buffer_free <= 1'b1;
        end else begin
            if (ss_fall_c && !wr_buffer_free) begin
                // Word consumed into the shift register.
                wr_buffer_free <= 1'b1;
            end else if (wr_en && wr_buffer_free) begin
                tx_buf         <= wr_data;
                wr_buffer_free <= 1'b0;
            end
        end
    end

    // MISO shifter: first bit presented at frame start, next bit on each SCK fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift <= '0;
            SPI_MISO <= 1'b0;
        end else begin
            if (ss_fall_c) begin
                SPI_MISO <= tx_load_c[31];
                tx_shift <= {tx_load_c[30:0], 1'b0};
            end else if (!frame_active) begin
                // Unsent bits of an ended frame are dropped.
                SPI_MISO <= 1'b0;
                tx_shift <= '0;
            end else if (sck_fall_c) begin
                SPI_MISO <= tx_shift[31];
                tx_shift <= {tx_shift[30:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
// Bench for spi_slave: a behavioural SPI mode-0 master drives frames; frames
// expected to be accepted are queued and checked when rd_data_available rises.
// ---------------------------------------------------------------------------
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        SPI_SCK = 1'b0;
    logic        SPI_SS = 1'b1;
    logic        SPI_MOSI = 1'b0;
    logic        SPI_MISO;
    logic        wr_buffer_free;
    logic        wr_en = 1'b0;
    logic [23:0] wr_data = '0;
    logic        rd_data_available;
    logic        rd_ack = 1'b0;
    logic [31:0] rd_data;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] rx_q[$];
    logic        avail_prev = 1'b0;

    spi_slave dut (
        .clk               (clk),
        .reset             (reset),
        .SPI_SCK           (SPI_SCK),
        .SPI_SS            (SPI_SS),
        .SPI_MOSI          (SPI_MOSI),
        .SPI_MISO          (SPI_MISO),
        .wr_buffer_free    (wr_buffer_free),
        .wr_en             (wr_en),
        .wr_data           (wr_data),
        .rd_data_available (rd_data_available),
        .rd_ack            (rd_ack),
        .rd_data           (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every new frame hand-over must match the oldest queued frame.
    always @(negedge clk) begin
        if (rd_data_available && !avail_prev) begin
            if (rx_q.size() == 0)
                check("rx_unexpected_frame", 32'(rd_data_available), 32'd0);
            else
                check("rx_frame", rd_data, rx_q.pop_front());
        end
        avail_prev = rd_data_available;
    end

    // Mode-0 master; SCK half period 40 ns (8 clk per SCK period).
    // Byte i of word (word[8i+7:8i]) is sent i-th, MSB-first.
    task automatic spi_xfer(input logic [31:0] word, input int nbits,
                            output logic [31:0] miso_word, output logic avail_end);
        miso_word = '0;
        avail_end = 1'b0;
        SPI_SS = 1'b0;
        #60;
        for (int i = 0; i < nbits; i++) begin
            int bidx;
            int bpos;
            bidx = i / 8;
            bpos = 7 - (i % 8);
            SPI_MOSI = word[bidx * 8 + bpos];
            #40;
            SPI_SCK = 1'b1;
            miso_word = {miso_word[30:0], SPI_MISO};
            #40;
            if (i == 31) avail_end = rd_data_available;
            SPI_SCK = 1'b0;
        end
        #40;
        SPI_SS   = 1'b1;
        SPI_MOSI = 1'b0;
        #80;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    task automatic write_word(input logic [23:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] m;
        logic        a;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_avail", 32'(rd_data_available), 32'd0);
        check("rst_free", 32'(wr_buffer_free), 32'd1);
        check("rst_miso", 32'(SPI_MISO), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic receive, empty transmit buffer
        rx_q.push_back(32'hCCBBAA01);
        spi_xfer(32'hCCBBAA01, 32, m, a);
        check("t1_miso_empty", m, 32'h0);
        check("t1_avail_latency", 32'(a), 32'd1);
        check("t1_avail_hold", 32'(rd_data_available), 32'd1);
        ack_pulse();
        check("t1_avail_cleared", 32'(rd_data_available), 32'd0);
        check("t1_rd_data_kept", rd_data, 32'hCCBBAA01);

        // Transmit a buffered word
        write_word(24'h123456);
        check("t2_free_low", 32'(wr_buffer_free), 32'd0);
        rx_q.push_back(32'h44332211);
        spi_xfer(32'h44332211, 32, m, a);
        check("t2_miso_word", m, 32'h01563412);
        check("t2_free_high", 32'(wr_buffer_free), 32'd1);
        ack_pulse();

        // Empty buffer again
        rx_q.push_back(32'h87654321);
        spi_xfer(32'h87654321, 32, m, a);
        check("t3_miso_empty", m, 32'h0);
        ack_pulse();

        // Second frame without ack is dropped
        rx_q.push_back(32'hA5A50F02);
        spi_xfer(32'hA5A50F02, 32, m, a);
        spi_xfer(32'h5A5AF003, 32, m, a);
        check("t4_rd_data_first", rd_data, 32'hA5A50F02);
        check("t4_avail", 32'(rd_data_available), 32'd1);
        ack_pulse();

        // Partial frame is discarded, next full frame received
        spi_xfer(32'hFFFFFF04, 12, m, a);
        repeat (10) @(negedge clk);
        check("t5_no_avail", 32'(rd_data_available), 32'd0);
        rx_q.push_back(32'h13579B05);
        spi_xfer(32'h13579B05, 32, m, a);
        check("t5_rd_data", rd_data, 32'h13579B05);
        ack_pulse();

        // Writes while not free are ignored
        write_word(24'hABCDEF);
        write_word(24'h111111);
        check("t6_free_low", 32'(wr_buffer_free), 32'd0);
        rx_q.push_back(32'h0BADF00D);
        spi_xfer(32'h0BADF00D, 32, m, a);
        check("t6_miso_first", m, 32'h01EFCDAB);
        ack_pulse();
        rx_q.push_back(32'hC0FFEE06);
        spi_xfer(32'hC0FFEE06, 32, m, a);
        check("t6_miso_second_empty", m, 32'h0);
        ack_pulse();

        // rd_ack while nothing held is ignored
        ack_pulse();
        check("t7_avail_low", 32'(rd_data_available), 32'd0);
        check("t7_rd_data_kept", rd_data, 32'hC0FFEE06);

        // Reset mid-frame abandons the frame and empties the buffer
        write_word(24'h777777);
        fork
            spi_xfer(32'hDEADBE07, 32, m, a);
            begin
                #400;
                reset = 1'b1;
                #20;
                check("t8_rst_rd_data", rd_data, 32'h0);
                check("t8_rst_avail", 32'(rd_data_available), 32'd0);
                check("t8_rst_free", 32'(wr_buffer_free), 32'd1);
                check("t8_rst_miso", 32'(SPI_MISO), 32'd0);
                #30;
                reset = 1'b0;
            end
        join
        check("t8_no_frame", 32'(rd_data_available), 32'd0);
        rx_q.push_back(32'h2468ACE0);
        spi_xfer(32'h2468ACE0, 32, m, a);
        check("t8_miso_empty", m, 32'h0);
        check("t8_rd_data", rd_data, 32'h2468ACE0);
        ack_pulse();

        repeat (5) @(negedge clk);
        check("rx_queue_drained", 32'(rx_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
